// File: rtl/calc_sequencer_if.sv
// Key-token handshake and arithmetic-unit bus for the calculator sequencer.
// slave = sequencer side, master = key decoder / AU / observer side.
interface calc_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
);
    logic              key_valid;
    logic              key_ready;
    logic [1:0]        key_kind;
    logic [DATA_W-1:0] key_data;
    logic [1:0]        au_signal;
    logic [DATA_W-1:0] au_a;
    logic [DATA_W-1:0] au_b;
    logic [RES_W-1:0]  au_result;
    logic [RES_W-1:0]  result;
    logic              result_valid;
    logic              done;
    logic              neg;
    logic              err;
    logic [2:0]        state_dbg;

    modport slave (
        input  key_valid, key_kind, key_data, au_result,
        output key_ready, au_signal, au_a, au_b,
        output result, result_valid, done, neg, err, state_dbg
    );

    modport master (
        output key_valid, key_kind, key_data, au_result,
        input  key_ready, au_signal, au_a, au_b,
        input  result, result_valid, done, neg, err, state_dbg
    );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator control FSM: collects A/op/B key tokens, drives the AU,
// waits SETTLE_CYC cycles, then captures and holds the AU result.
// Ports: clk, rst (async, active-high), bus (calc_sequencer_if.slave).
module calc_sequencer #(
    parameter int DATA_W     = 8,
    parameter int RES_W      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    calc_sequencer_if.slave   bus
);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [1:0] K_OPND = 2'b00;
    localparam logic [1:0] K_OPER = 2'b01;
    localparam logic [1:0] K_EQ   = 2'b10;
    localparam logic [1:0] K_CLR  = 2'b11;
    localparam logic [1:0] OP_SUB = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_A  = 3'd1,
        GOT_OP = 3'd2,
        GOT_B  = 3'd3,
        EXEC   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic xfer, is_opnd, is_oper, is_eq, is_clr, bad_op;
    logic want_a, want_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        err_d   = err_q;
        done_d  = 1'b0;

        xfer    = bus.key_valid && (state_q != EXEC);
        is_opnd = bus.key_kind == K_OPND;
        is_oper = (bus.key_kind == K_OPER) && (bus.key_data[1:0] != 2'b00);
        bad_op  = (bus.key_kind == K_OPER) && (bus.key_data[1:0] == 2'b00);
        is_eq   = bus.key_kind == K_EQ;
        is_clr  = bus.key_kind == K_CLR;
        want_a  = (state_q == IDLE) || (state_q == GOT_A) || (state_q == DONE);
        want_b  = (state_q == GOT_OP) || (state_q == GOT_B);

        if (state_q == EXEC) begin
            if (cnt_q == '0) begin
                res_d   = bus.au_result;
                neg_d   = (op_q == OP_SUB) && (a_q < b_q);
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (xfer) begin
            unique case (1'b1)
                is_clr: begin
                    state_d = IDLE;
                    a_d     = '0;
                    b_d     = '0;
                    op_d    = '0;
                    res_d   = '0;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                    err_d   = 1'b0;
                end
                is_opnd && want_a: begin
                    a_d     = bus.key_data;
                    state_d = GOT_A;
                end
                is_opnd && want_b: begin
                    b_d     = bus.key_data;
                    state_d = GOT_B;
                end
                is_oper && ((state_q == GOT_A) || (state_q == GOT_OP)): begin
                    op_d    = bus.key_data[1:0];
                    state_d = GOT_OP;
                end
                // Chaining feeds only the low byte back as A; a wider
                // result cannot be represented, so flag it.
                is_oper && (state_q == DONE): begin
                    a_d     = res_q[DATA_W-1:0];
                    op_d    = bus.key_data[1:0];
                    state_d = GOT_OP;
                    if (res_q[RES_W-1:DATA_W] != '0)
                        err_d = 1'b1;
                end
                is_eq && (state_q == GOT_A): begin
                    op_d    = 2'b00;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                    state_d = EXEC;
                end
                is_eq && (state_q == GOT_B): begin
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                    state_d = EXEC;
                end
                is_eq && (state_q == DONE): begin
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    assign bus.key_ready    = (state_q != EXEC);
    assign bus.au_signal    = (state_q == EXEC) ? op_q : 2'b00;
    assign bus.au_a         = a_q;
    assign bus.au_b         = b_q;
    assign bus.result       = res_q;
    assign bus.result_valid = (state_q == DONE);
    assign bus.done         = done_q;
    assign bus.neg          = neg_q;
    assign bus.err          = err_q;
    assign bus.state_dbg    = state_q;

    logic unused_bad_op;
    assign unused_bad_op = bad_op;
endmodule
